obstacle_sched: RTL and testbench



---
 rtl/obstacle_sched_pkg.sv | 87 ++++++++
 rtl/obstacle_sched_lfsr16.sv | 28 ++
 rtl/obstacle_sched.sv | 118 +++++++++++
 tb/tb_obstacle_sched.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_sched_pkg.sv
// Shared packed object-data layout, game-state and obstacle type codes, and
// per-type geometry used by the scheduler, renderer and collision logic.
package obstacle_sched_pkg;

   localparam int DATATLEN = 3;
   localparam int DATAXLEN = 10;
   localparam int DATAYLEN = 9;
   localparam int DATAWLEN = 7;
   localparam int DATAHLEN = 7;
   localparam int DATALEN  = DATATLEN + DATAXLEN + DATAYLEN + DATAWLEN + DATAHLEN;

   localparam int DEF_SPAWN_X = 640;
   localparam int GAPLEN      = 7;
   localparam int SCORELEN    = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_OVER   = 2'd3
   } state_e;

   typedef enum logic [DATATLEN-1:0] {
      OT_NULL         = 3'd0,
      OT_GROUND       = 3'd1,
      OT_CACTUS_SMALL = 3'd2,
      OT_CACTUS_LARGE = 3'd3,
      OT_BIRD         = 3'd4
   } otype_e;

   // Field order fixes the bit layout: type in the MSBs, height in the LSBs.
   typedef struct packed {
      otype_e              otype;
      logic [DATAXLEN-1:0] x;
      logic [DATAYLEN-1:0] y;
      logic [DATAWLEN-1:0] w;
      logic [DATAHLEN-1:0] h;
   } obj_t;

   localparam logic [DATAYLEN-1:0] CS_Y = 9'd368;
   localparam logic [DATAWLEN-1:0] CS_W = 7'd16;
   localparam logic [DATAHLEN-1:0] CS_H = 7'd32;
   localparam logic [DATAYLEN-1:0] CL_Y = 9'd352;
   localparam logic [DATAWLEN-1:0] CL_W = 7'd24;
   localparam logic [DATAHLEN-1:0] CL_H = 7'd48;
   localparam logic [DATAYLEN-1:0] BD_Y = 9'd320;
   localparam logic [DATAWLEN-1:0] BD_W = 7'd32;
   localparam logic [DATAHLEN-1:0] BD_H = 7'd24;

   function automatic otype_e lfsr_to_type(input logic [1:0] sel);
      otype_e t;
      case (sel)
         2'd2:    t = OT_CACTUS_LARGE;
         2'd3:    t = OT_BIRD;
         default: t = OT_CACTUS_SMALL;
      endcase
      return t;
   endfunction

   function automatic obj_t make_obj(input otype_e t, input logic [DATAXLEN-1:0] x);
      obj_t r;
      r       = '0;
      r.otype = t;
      r.x     = x;
      case (t)
         OT_CACTUS_SMALL: begin r.y = CS_Y; r.w = CS_W; r.h = CS_H; end
         OT_CACTUS_LARGE: begin r.y = CL_Y; r.w = CL_W; r.h = CL_H; end
         OT_BIRD:         begin r.y = BD_Y; r.w = BD_W; r.h = BD_H; end
         default:         r = '0;
      endcase
      return r;
   endfunction

   // An obstacle that would scroll past x=0 is retired rather than wrapped.
   function automatic obj_t scroll_obj(input obj_t o, input logic [2:0] s);
      obj_t                r;
      logic [DATAXLEN-1:0] sx;
      sx = DATAXLEN'(s);
      r  = o;
      if (o.otype != OT_NULL) begin
         if (o.x >= sx) r.x = o.x - sx;
         else           r   = '0;
      end
      return r;
   endfunction

endpackage

// File: rtl/obstacle_sched_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11) with step enable and synchronous
// reload to the seed; drives obstacle type and spawn spacing.
module obstacle_sched_lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        load_i,
   input  logic        en_i,
   output logic [15:0] lfsr_o
);

   localparam logic [15:0] TAPS = 16'hB400;

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en_i) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
   end

   always_ff @(posedge clk_i) begin
      if (load_i) lfsr_q <= SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/obstacle_sched.sv
// Runner game-state sequencer and obstacle slot scheduler: spawns obstacles at
// the right edge and scrolls them left on each tick while running.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start; slots frozen and still visible
//   ST_RUN    | ticks scroll, spawn, score and advance the LFSR
//   ST_PAUSED | pause held high; everything frozen, collide ignored
//   ST_OVER   | collision seen; frozen until start drops
module obstacle_sched
   import obstacle_sched_pkg::*;
#(
   parameter int          SLOTS     = 4,
   parameter int          SPAWN_X   = DEF_SPAWN_X,
   parameter int          MIN_GAP   = 40,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                     clk3,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     pause,
   input  logic                     collide,
   input  logic                     tick,
   input  logic [2:0]               speed,
   input  logic [$clog2(SLOTS)-1:0] slot_sel,
   output logic [DATALEN-1:0]       obj_out,
   output logic [1:0]               state,
   output logic [SCORELEN-1:0]      score
);

   state_e                  state_q, state_d;
   obj_t [SLOTS-1:0]        slots_q, slots_d;
   obj_t                    obj_q, sel_obj, spawn_obj;
   logic [GAPLEN-1:0]       gap_q, gap_d;
   logic [SCORELEN-1:0]     score_q, score_d;
   logic [SLOTS-1:0]        free, pick;
   logic [15:0]             lfsr;
   logic                    lfsr_unused;
   logic [2:0]              s_eff;
   logic                    enter_run, run_tick, gap_zero, spawn_now;

   obstacle_sched_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk_i  (clk3),
      .load_i (reset),
      .en_i   (run_tick),
      .lfsr_o (lfsr)
   );

   assign lfsr_unused = ^lfsr[15:8];

   always_comb begin
      state_d   = state_q;
      enter_run = 1'b0;
      case (state_q)
         ST_IDLE:   if (start) begin state_d = ST_RUN; enter_run = 1'b1; end
         ST_RUN:    if (collide) state_d = ST_OVER;
                    else if (pause) state_d = ST_PAUSED;
         ST_PAUSED: if (!pause) state_d = ST_RUN;
         ST_OVER:   if (!start) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // A tick is consumed only when the run stays in RUN this cycle.
   assign run_tick  = (state_q == ST_RUN) && tick && !collide && !pause;
   assign s_eff     = (speed == 3'd0) ? 3'd1 : speed;
   assign gap_zero  = (gap_q == '0);
   assign spawn_now = run_tick && gap_zero;
   assign spawn_obj = make_obj(lfsr_to_type(lfsr[1:0]), DATAXLEN'(SPAWN_X));

   // Freedom is judged on pre-scroll contents, so a slot retired this tick
   // cannot be refilled until the next one.
   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      localparam logic [SLOTS-1:0] LOWER = SLOTS'((1 << i) - 1);
      assign free[i]    = (slots_q[i].otype == OT_NULL);
      assign pick[i]    = free[i] & ~|(free & LOWER);
      assign slots_d[i] = enter_run              ? obj_t'('0)  :
                          !run_tick              ? slots_q[i]  :
                          (spawn_now && pick[i]) ? spawn_obj   :
                                                   scroll_obj(slots_q[i], s_eff);
   end

   always_comb begin
      gap_d   = gap_q;
      score_d = score_q;
      if (enter_run) begin
         gap_d   = GAPLEN'(MIN_GAP);
         score_d = '0;
      end else if (run_tick) begin
         if (!gap_zero)  gap_d = gap_q - GAPLEN'(1);
         else if (|free) gap_d = GAPLEN'(MIN_GAP) + {1'b0, lfsr[7:2]};
         if (score_q != '1) score_d = score_q + SCORELEN'(1);
      end
   end

   assign sel_obj = (int'(slot_sel) < SLOTS) ? slots_q[slot_sel] : obj_t'('0);

   always_ff @(posedge clk3) begin
      if (reset) begin
         state_q <= ST_IDLE;
         slots_q <= '0;
         gap_q   <= GAPLEN'(MIN_GAP);
         score_q <= '0;
         obj_q   <= '0;
      end else begin
         state_q <= state_d;
         slots_q <= slots_d;
         gap_q   <= gap_d;
         score_q <= score_d;
         obj_q   <= sel_obj;
      end
   end

   assign obj_out = obj_q;
   assign state   = state_q;
   assign score   = score_q;

endmodule

// File: tb/tb_obstacle_sched.sv
// Randomised scoreboard bench for obstacle_sched against a behavioural game model.
module tb_obstacle_sched;

   localparam int SLOTS   = 4;
   localparam int SPAWN_X = 640;
   localparam int MIN_GAP = 4;

   logic        clk3 = 1'b0;
   logic        reset = 1'b1, start = 1'b0, pause = 1'b0, collide = 1'b0, tick = 1'b0;
   logic [2:0]  speed = 3'd1;
   logic [1:0]  slot_sel = 2'd0;
   logic [35:0] obj_out;
   logic [1:0]  state;
   logic [15:0] score;

   obstacle_sched #(.SLOTS(SLOTS), .SPAWN_X(SPAWN_X), .MIN_GAP(MIN_GAP),
                    .LFSR_SEED(16'hACE1)) dut (
      .clk3(clk3), .reset(reset), .start(start), .pause(pause), .collide(collide),
      .tick(tick), .speed(speed), .slot_sel(slot_sel), .obj_out(obj_out),
      .state(state), .score(score));

   always #5 clk3 = ~clk3;

   typedef struct packed {
      logic [1:0]  st;
      logic [15:0] sc;
      logic [35:0] ob;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // model: types 0 none, 2 small cactus, 3 large cactus, 4 bird
   int          m_state = 0;
   int          m_type[SLOTS];
   int          m_x[SLOTS];
   int          m_gap = MIN_GAP;
   int          m_score = 0;
   logic [15:0] m_lfsr = 16'hACE1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [35:0] desc(input int t, input int x);
      int y, w, h;
      case (t)
         2: begin y = 368; w = 16; h = 32; end
         3: begin y = 352; w = 24; h = 48; end
         4: begin y = 320; w = 32; h = 24; end
         default: return 36'd0;
      endcase
      return {3'(t), 10'(x), 9'(y), 7'(w), 7'(h)};
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   task automatic model_tick(input int spd);
      int s, idx;
      bit was_free[SLOTS];
      s = (spd == 0) ? 1 : spd;
      for (int i = 0; i < SLOTS; i++) was_free[i] = (m_type[i] == 0);
      for (int i = 0; i < SLOTS; i++)
         if (m_type[i] != 0) begin
            if (m_x[i] >= s) m_x[i] -= s;
            else begin m_type[i] = 0; m_x[i] = 0; end
         end
      if (m_gap > 0) m_gap--;
      else begin
         idx = -1;
         for (int i = SLOTS - 1; i >= 0; i--) if (was_free[i]) idx = i;
         if (idx >= 0) begin
            case (m_lfsr & 16'd3)
               16'd2:   m_type[idx] = 3;
               16'd3:   m_type[idx] = 4;
               default: m_type[idx] = 2;
            endcase
            m_x[idx] = SPAWN_X;
            m_gap    = MIN_GAP + int'((m_lfsr >> 2) & 16'd63);
         end
      end
      if (m_score < 65535) m_score++;
      m_lfsr = lfsr_next(m_lfsr);
   endtask

   task automatic model_step(input bit r, input bit st, input bit pa, input bit co,
                             input bit ti, input int spd);
      if (r) begin
         m_state = 0; m_score = 0; m_gap = MIN_GAP; m_lfsr = 16'hACE1;
         for (int i = 0; i < SLOTS; i++) begin m_type[i] = 0; m_x[i] = 0; end
         return;
      end
      case (m_state)
         0: if (st) begin
               m_state = 1; m_score = 0; m_gap = MIN_GAP;
               for (int i = 0; i < SLOTS; i++) begin m_type[i] = 0; m_x[i] = 0; end
            end
         1: if (co) m_state = 3;
            else if (pa) m_state = 2;
            else if (ti) model_tick(spd);
         2: if (!pa) m_state = 1;
         default: if (!st) m_state = 0;
      endcase
   endtask

   task automatic cycle(input bit r, input bit st, input bit pa, input bit co,
                        input bit ti, input int spd, input int sel);
      exp_t e;
      #1;
      reset = r; start = st; pause = pa; collide = co; tick = ti;
      speed = 3'(spd); slot_sel = 2'(sel);
      e.ob = r ? 36'd0 : desc(m_type[sel], m_x[sel]);
      model_step(r, st, pa, co, ti, spd);
      e.st = 2'(m_state);
      e.sc = 16'(m_score);
      sb.push_back(e);
      @(posedge clk3);
      @(negedge clk3);
   endtask

   always @(negedge clk3) begin : monitor
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("state", {62'd0, state}, {62'd0, e.st});
         chk("score", {48'd0, score}, {48'd0, e.sc});
         chk("obj_out", {28'd0, obj_out}, {28'd0, e.ob});
      end
   end

   initial begin : driver
      int pcnt, ps;
      for (int i = 0; i < SLOTS; i++) begin m_type[i] = 0; m_x[i] = 0; end
      @(negedge clk3);
      repeat (3) cycle(1, 1, 0, 0, 1, 1, 0);
      chk("rst_state", {62'd0, state}, 64'd0);
      chk("rst_score", {48'd0, score}, 64'd0);

      // first spawn on tick MIN_GAP+1, then 10 ticks at speed 2
      cycle(0, 1, 0, 0, 0, 2, 0);
      chk("run_state", {62'd0, state}, 64'd1);
      repeat (4) cycle(0, 1, 0, 0, 1, 2, 0);
      cycle(0, 1, 0, 0, 1, 2, 0);
      chk("pre_spawn_null", {28'd0, obj_out}, 64'd0);
      cycle(0, 1, 0, 0, 0, 2, 0);
      chk("spawn_x", {54'd0, obj_out[32:23]}, 64'd640);
      repeat (10) cycle(0, 1, 0, 0, 1, 2, 0);
      cycle(0, 1, 0, 0, 0, 2, 0);
      chk("scroll_x", {54'd0, obj_out[32:23]}, 64'd620);

      // pause holds everything for 20 ticks
      ps = m_score;
      repeat (20) cycle(0, 1, 1, 0, 1, 3, int'($urandom_range(0, 3)));
      chk("pause_state", {62'd0, state}, 64'd2);
      chk("pause_score", {48'd0, score}, 64'(ps));
      cycle(0, 1, 0, 1, 1, 3, 0);
      chk("resume_state", {62'd0, state}, 64'd1);

      // slow scroll fills every slot and parks gap at 0, then fast scroll frees them
      repeat (400) cycle(0, 1, 0, 0, 1, 1, int'($urandom_range(0, 3)));
      repeat (200) cycle(0, 1, 0, 0, 1, 7, int'($urandom_range(0, 3)));
      repeat (150) cycle(0, 1, 0, 0, 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

      // reset mid-run discards all slots
      repeat (3) cycle(1, 1, 0, 0, 1, 1, 0);
      for (int k = 0; k < SLOTS; k++) begin
         cycle(0, 0, 0, 0, 1, 1, k);
         chk("post_rst_obj", {28'd0, obj_out}, 64'd0);
      end

      // randomised play
      pcnt = 0;
      repeat (2500) begin
         if ($urandom_range(0, 99) == 0) pcnt = int'($urandom_range(1, 25));
         cycle(0, $urandom_range(0, 9) != 0, pcnt > 0, $urandom_range(0, 299) == 0,
               1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)));
         if (pcnt > 0) pcnt--;
      end

      // collide beats pause; slots stay visible through OVER and IDLE
      while (m_state != 1) cycle(0, m_state != 3, 0, 0, 0, 1, 0);
      repeat (120) cycle(0, 1, 0, 0, 1, 2, 0);
      cycle(0, 1, 1, 1, 1, 2, 0);
      chk("collide_over", {62'd0, state}, 64'd3);
      cycle(0, 0, 0, 0, 1, 2, 0);
      chk("over_idle", {62'd0, state}, 64'd0);
      for (int k = 0; k < 8; k++) cycle(0, 0, 0, 0, 1, 5, k % SLOTS);

      #2;
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
